// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline return buffer.
// Status export layout and counter width helper.
package pipe_pkg;

  localparam int STATUS_W = 16;

  function automatic int clog2_plus1(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [STATUS_W-1:0] count;
    logic [STATUS_W-1:0] inflight;
  } status_t;

endpackage

// File: rtl/return_fifo_mem.sv
// Result storage: DEPTH x WIDTH register array, one write port, async read.
// Contents are deliberately left unreset.
module return_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_return_buffer.sv
// Credit-gated return buffer for a fixed-latency, non-stallable pipe.
// Converts returning results into a backpressurable valid/ready stream.
module pipeline_return_buffer
  import pipe_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          issue_valid_in,
  output logic                          issue_ready_out,
  output logic                          issue_fire_out,
  input  logic                          ret_valid_in,
  input  logic [WIDTH-1:0]              ret_data_in,
  output logic                          out_valid_out,
  input  logic                          out_ready_in,
  output logic [WIDTH-1:0]              out_data_out,
  output logic [clog2_plus1(DEPTH)-1:0] count_out,
  output logic [clog2_plus1(DEPTH)-1:0] inflight_out,
  output logic                          error_out
);

  localparam int CW = clog2_plus1(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [CW-1:0]      count, inflight, free;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [LATENCY-1:0] expect_sr;
  logic               pop, push, expected, error;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  // Credits come from registered state only, so a pop frees a credit one cycle later.
  assign free            = FULL - count - inflight;
  assign issue_ready_out = (free != '0);
  assign issue_fire_out  = issue_valid_in & issue_ready_out;
  assign out_valid_out   = (count != '0);
  assign pop             = out_valid_out & out_ready_in;
  assign push            = ret_valid_in & ((count != FULL) | pop);
  assign expected        = expect_sr[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_sr_one
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) expect_sr <= '0;
        else           expect_sr <= issue_fire_out;
      end
    end else begin : g_sr_many
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) expect_sr <= '0;
        else           expect_sr <= {expect_sr[LATENCY-2:0], issue_fire_out};
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count    <= '0;
      inflight <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      error    <= 1'b0;
    end else begin
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (issue_fire_out && !ret_valid_in && inflight != FULL)
        inflight <= inflight + CW'(1);
      else if (ret_valid_in && !issue_fire_out && inflight != '0)
        inflight <= inflight - CW'(1);

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      // Unexpected return timing or an overflowing push latches the error.
      if ((ret_valid_in != expected) || (ret_valid_in && count == FULL && !pop))
        error <= 1'b1;
    end
  end

  return_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk_in),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (ret_data_in),
    .raddr (rd_ptr),
    .rdata (out_data_out)
  );

  assign count_out    = count;
  assign inflight_out = inflight;
  assign error_out    = error;

endmodule

// File: tb/tb_pipeline_return_buffer.sv
// Bench for pipeline_return_buffer with a 4-cycle external pipe model,
// a queue-based reference model, a vector table and corner-case sequences.
module tb_pipeline_return_buffer;

  localparam int LAT = 4;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int CW  = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          issue_valid_in = 1'b0;
  logic          issue_ready_out, issue_fire_out;
  logic          ret_valid_in;
  logic [W-1:0]  ret_data_in;
  logic          out_valid_out;
  logic          out_ready_in = 1'b0;
  logic [W-1:0]  out_data_out;
  logic [CW-1:0] count_out, inflight_out;
  logic          error_out;

  logic [W-1:0]  issue_data = '0;
  logic          inject = 1'b0;
  logic [W-1:0]  inject_data = 32'hDEAD_BEEF;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  pipeline_return_buffer #(.LATENCY(LAT), .WIDTH(W), .DEPTH(D)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .issue_valid_in  (issue_valid_in),
    .issue_ready_out (issue_ready_out),
    .issue_fire_out  (issue_fire_out),
    .ret_valid_in    (ret_valid_in),
    .ret_data_in     (ret_data_in),
    .out_valid_out   (out_valid_out),
    .out_ready_in    (out_ready_in),
    .out_data_out    (out_data_out),
    .count_out       (count_out),
    .inflight_out    (inflight_out),
    .error_out       (error_out)
  );

  // External pipe: exact LAT-cycle delay of fire and data, reset with the block.
  logic         pipe_v [LAT];
  logic [W-1:0] pipe_d [LAT];

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= issue_fire_out;
      pipe_d[0] <= issue_data;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign ret_valid_in = pipe_v[LAT-1] | inject;
  assign ret_data_in  = inject ? inject_data : pipe_d[LAT-1];

  task automatic check_output(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic ordy, input logic [W-1:0] data);
    @(posedge clk_in);
    #1;
    issue_valid_in = iv;
    out_ready_in   = ordy;
    issue_data     = data;
    @(negedge clk_in);
  endtask

  // Reference model: occupancy and inflight from event counting, order from a queue.
  bit           mon_en = 1'b0;
  int           m_count = 0;
  int           m_inflight = 0;
  int           pops = 0;
  logic [W-1:0] sb [$];

  always @(negedge clk_in) begin : monitor
    bit m_ready, m_fire, m_pop;
    if (mon_en && rst_n_in) begin
      m_ready = (D - m_count - m_inflight) > 0;
      m_fire  = issue_valid_in && m_ready;
      m_pop   = (m_count > 0) && out_ready_in;
      check_output("mon_count", count_out, m_count);
      check_output("mon_inflight", inflight_out, m_inflight);
      check_output("mon_out_valid", out_valid_out, m_count > 0);
      check_output("mon_issue_ready", issue_ready_out, m_ready);
      check_output("mon_issue_fire", issue_fire_out, m_fire);
      check_output("mon_error", error_out, 0);
      check_output("mon_budget", (count_out + inflight_out) <= D, 1);
      if (m_pop) begin
        if (sb.size() == 0) begin
          check_output("mon_pop_underflow", 1, 0);
        end else begin
          check_output("mon_data", out_data_out, sb.pop_front());
        end
        pops++;
      end
      if (m_fire) sb.push_back(issue_data);
      if (m_fire) m_inflight++;
      if (ret_valid_in) begin
        m_inflight--;
        m_count++;
      end
      if (m_pop) m_count--;
    end
  end

  task automatic reset_dut();
    mon_en = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    issue_valid_in = 1'b0;
    out_ready_in = 1'b0;
    inject = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    m_count = 0;
    m_inflight = 0;
    sb.delete();
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      apply_stimulus(1'b0, 1'b1, '0);
      if (count_out == 0 && inflight_out == 0) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: timeout, count=%0d inflight=%0d, expected both 0",
               name, count_out, inflight_out);
    end
  endtask

  typedef struct {
    logic         iv;
    logic         ordy;
    logic [W-1:0] data;
    logic         e_valid;
    int           e_count;
    int           e_infl;
    logic         e_ready;
    logic         e_fire;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int fired, first_full, pops_before, id;
    logic sticky;

    vecs[0] = '{1, 0, 32'hA5A5_0001, 0, 0, 0, 1, 1, 0};
    vecs[1] = '{0, 0, 0,             0, 0, 1, 1, 0, 0};
    vecs[2] = '{0, 0, 0,             0, 0, 1, 1, 0, 0};
    vecs[3] = '{0, 0, 0,             0, 0, 1, 1, 0, 0};
    vecs[4] = '{0, 0, 0,             0, 0, 1, 1, 0, 0};
    vecs[5] = '{0, 0, 0,             1, 1, 0, 1, 0, 32'hA5A5_0001};
    vecs[6] = '{0, 1, 0,             1, 1, 0, 1, 0, 32'hA5A5_0001};
    vecs[7] = '{0, 0, 0,             0, 0, 0, 1, 0, 0};

    reset_dut();
    @(negedge clk_in);
    check_output("reset_out_valid", out_valid_out, 0);
    check_output("reset_issue_ready", issue_ready_out, 1);
    check_output("reset_error", error_out, 0);
    check_output("reset_count", count_out, 0);
    check_output("reset_inflight", inflight_out, 0);
    repeat (8) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] single-op vector table");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].iv, vecs[i].ordy, vecs[i].data);
      check_output($sformatf("vec%0d_out_valid", i), out_valid_out, vecs[i].e_valid);
      check_output($sformatf("vec%0d_count", i), count_out, vecs[i].e_count);
      check_output($sformatf("vec%0d_inflight", i), inflight_out, vecs[i].e_infl);
      check_output($sformatf("vec%0d_issue_ready", i), issue_ready_out, vecs[i].e_ready);
      check_output($sformatf("vec%0d_issue_fire", i), issue_fire_out, vecs[i].e_fire);
      check_output($sformatf("vec%0d_error", i), error_out, 0);
      if (vecs[i].e_valid)
        check_output($sformatf("vec%0d_data", i), out_data_out, vecs[i].e_data);
    end

    $display("[TB] streaming");
    mon_en = 1'b1;
    pops_before = pops;
    id = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, 1'b1, id);
      check_output("stream_fire", issue_fire_out, 1);
      check_output("stream_count_le1", count_out <= 1, 1);
      if (issue_fire_out) id++;
    end
    wait_idle("stream_drain");
    check_output("stream_pops", pops - pops_before, 100);
    check_output("stream_sb_empty", sb.size(), 0);

    $display("[TB] backpressure");
    fired = 0;
    first_full = -1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h1000 + fired);
      if (issue_fire_out) fired++;
      if (count_out == 8 && first_full < 0) first_full = i;
    end
    check_output("bp_fires", fired, 8);
    check_output("bp_full_cycle", first_full, 12);
    check_output("bp_count", count_out, 8);
    check_output("bp_issue_ready", issue_ready_out, 0);
    pops_before = pops;
    apply_stimulus(1'b0, 1'b1, '0);
    check_output("bp_ready_pop_cycle", issue_ready_out, 0);
    apply_stimulus(1'b0, 1'b1, '0);
    check_output("bp_ready_after_pop", issue_ready_out, 1);
    wait_idle("bp_drain");
    check_output("bp_pops", pops - pops_before, 8);

    $display("[TB] wrap with random backpressure");
    fired = 0;
    pops_before = pops;
    for (int i = 0; i < 500 && fired < 20; i++) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 32'h2000 + fired);
      if (issue_fire_out) fired++;
    end
    check_output("wrap_fires", fired, 20);
    wait_idle("wrap_drain");
    check_output("wrap_pops", pops - pops_before, 20);

    $display("[TB] random stress");
    for (int i = 0; i < 400; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    wait_idle("random_drain");
    check_output("random_sb_empty", sb.size(), 0);

    $display("[TB] protocol error");
    mon_en = 1'b0;
    @(posedge clk_in);
    #1;
    inject = 1'b1;
    @(negedge clk_in);
    check_output("err_before_edge", error_out, 0);
    @(posedge clk_in);
    #1;
    inject = 1'b0;
    @(negedge clk_in);
    check_output("err_set", error_out, 1);
    sticky = 1'b1;
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(1'b0, 1'b1, '0);
      sticky = sticky & error_out;
    end
    check_output("err_sticky", sticky, 1);

    $display("[TB] async reset mid-stream");
    reset_dut();
    @(negedge clk_in);
    check_output("rst2_error_clear", error_out, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 32'h3000 + i);
    fired = 0;
    for (int i = 0; i < 20 && count_out != 5; i++) begin
      apply_stimulus(1'b0, 1'b0, '0);
      fired++;
    end
    check_output("mid_count", count_out, 5);
    check_output("mid_inflight", inflight_out, 3);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_output("async_out_valid", out_valid_out, 0);
    check_output("async_count", count_out, 0);
    check_output("async_inflight", inflight_out, 0);
    check_output("async_issue_ready", issue_ready_out, 1);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (6) apply_stimulus(1'b0, 1'b0, '0);
    check_output("post_rst_error", error_out, 0);
    check_output("post_rst_out_valid", out_valid_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_return_buffer.md
Name: pipeline_return_buffer

Overview:
- Sits at the output end of any fixed-latency, non-stallable datapath built from delay stages.
- Gates issue into that datapath with credits, so every result that emerges LATENCY cycles later always has a guaranteed buffer slot.
- Turns the free-running result stream into a valid/ready stream that downstream logic may backpressure.
- Also checks that results return exactly LATENCY cycles after issue.

Parameters:
- LATENCY, 4: cycles from issue_fire_out high to the matching ret_valid_in high; must be >= 1.
- WIDTH, 32: result data width.
- DEPTH, 8: result buffer entries; must be >= 1, power of two. Throughput is full when DEPTH >= LATENCY+1.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- issue_valid_in  input  1  upstream wants to launch an operation into the external pipe.
- issue_ready_out  output  1  a credit is available; operation may launch.
- issue_fire_out  output  1  issue_valid_in & issue_ready_out; drives the external pipe's valid input.
- ret_valid_in  input  1  result emerging from the external pipe.
- ret_data_in  input  WIDTH  result data, qualified by ret_valid_in.
- out_valid_out  output  1  buffer non-empty.
- out_ready_in  input  1  downstream accepts.
- out_data_out  output  WIDTH  head-of-buffer data.
- count_out  output  $clog2(DEPTH+1)  entries currently buffered.
- inflight_out  output  $clog2(DEPTH+1)  operations issued and not yet returned.
- error_out  output  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release):
  - count, inflight, read pointer, write pointer, expected-return shift register and error_out all go to 0.
  - Buffer RAM contents are not reset.
  - After reset: out_valid_out=0, issue_ready_out=1, error_out=0.
- Credits:
  - free = DEPTH - count - inflight, computed from registered values only, with width $clog2(DEPTH+1).
  - issue_ready_out = (free != 0); this is combinational from registers and never depends on issue_valid_in.
  - A pop in cycle N does not grant a credit until cycle N+1. This is fixed for timing.
- Inflight counter:
  - +1 on issue_fire_out, -1 on ret_valid_in; both in the same cycle leaves it unchanged.
- Buffer:
  - Push on ret_valid_in, writing ret_data_in at the write pointer.
  - Pop on out_valid_out & out_ready_in.
  - First-word-fall-through: out_data_out = mem[rd_ptr] and out_valid_out = (count != 0), both from registers.
  - Minimum latency from ret_valid_in to out_valid_out is 1 cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - With count=DEPTH and a simultaneous push+pop, the push is accepted.
- Expected-return check:
  - Internal LATENCY-deep shift register of issue_fire_out; bit LATENCY-1 equals "expected return this cycle".
  - error_out sets and holds until reset when ret_valid_in != expected, or on a push while count=DEPTH without a simultaneous pop.
  - On error the buffer write is still performed if a slot exists and otherwise dropped. Counters saturate at 0 and DEPTH, never wrap.
- Drain / mid-operation reset:
  - Asserting rst_n_in low discards all buffered and in-flight results immediately.
  - Results still emerging from the external pipe after release are flagged as errors. The owner of the external pipe must reset it together with this block.
- Invariant: count + inflight <= DEPTH in every cycle when there is no error.

Decomposition:
- Shared package pipe_pkg:
  - function clog2_plus1(DEPTH) for counter widths;
  - typedef struct {count, inflight} for status export.
- Sub-module return_fifo_mem: DEPTH x WIDTH register array with write port and async read port; no reset.
- Counters, credit logic and expected-return shifter stay in the top.

Test Plan (LATENCY=4, DEPTH=8, WIDTH=32; bench models the external pipe as an exact 4-cycle delay of issue_fire_out and data):
- Single op: issue_valid_in pulse with data 0xA5A5_0001 at cycle 10 -> ret at 14, out_valid_out=1 at 15 with out_data_out=0xA5A5_0001, inflight back to 0 at 15, error_out=0.
- Streaming, out_ready_in=1, issue_valid_in held high for 100 cycles -> issue_fire_out high every cycle; outputs in order 0..99; count never exceeds 1.
- Backpressure, out_ready_in=0, issue_valid_in held high -> exactly 8 fires, then issue_ready_out=0; count reaches 8 at the cycle after the 8th return; raising out_ready_in drains 8 in order, and issue_ready_out returns the cycle after the first pop.
- Wrap: 20 ops with random out_ready_in (50%) -> all 20 delivered in order; pointers wrap twice; count+inflight<=8 every cycle.
- Protocol error: inject ret_valid_in with no matching issue -> error_out=1 next cycle and stays high through 50 further clean cycles.
- Async reset mid-stream with count=5, inflight=3 -> out_valid_out=0, count_out=0, inflight_out=0, issue_ready_out=1 immediately on rst_n_in low, without waiting for a clock edge.
